btn_debounce_multi: RTL and testbench

Multi-channel, parametrised button debouncer with edge-event outputs. Each raw button input is synchronised to `clk` and sampled on the rate-generator tick. A change is accepted only after it holds for a configurable number of consecutive ticks. Per channel, the block emits a clean level plus one-cycle press and release pulses. It sits between the board push-buttons and the control FSMs (start/stop, mode select), which consume the release pulse.

---
 rtl/btn_debounce_multi.sv | 83 ++++++++
 tb/tb_btn_debounce_multi.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// Multi-channel button debouncer: 2-flop sync, tick-qualified stability count, press/release pulses.
// Optional long-press pulse generation is enabled by defining BTN_DEBOUNCE_LONGPRESS_EN.
module btn_debounce_multi #(
   parameter int CHANNELS     = 4,
   parameter int STABLE_TICKS = 3,
   parameter int LONG_TICKS   = 250
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rtg_btn,
   input  logic [CHANNELS-1:0] btn,
   output logic [CHANNELS-1:0] btn_state,
   output logic [CHANNELS-1:0] btn_press,
   output logic [CHANNELS-1:0] btn_release,
   output logic [CHANNELS-1:0] btn_long
);

   localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

   logic [CHANNELS-1:0] sync_q1;
   logic [CHANNELS-1:0] sync_q2;
   logic [CW-1:0]       cnt [CHANNELS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q1     <= '0;
         sync_q2     <= '0;
         btn_state   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      end else begin
         sync_q1     <= btn;
         sync_q2     <= sync_q1;
         btn_press   <= '0;
         btn_release <= '0;
         if (rtg_btn) begin
            for (int i = 0; i < CHANNELS; i++) begin
               // Any tick that agrees with the accepted level restarts qualification.
               if (sync_q2[i] == btn_state[i]) begin
                  cnt[i] <= '0;
               end else if (cnt[i] == CNT_MAX) begin
                  cnt[i]         <= '0;
                  btn_state[i]   <= sync_q2[i];
                  btn_press[i]   <= sync_q2[i];
                  btn_release[i] <= ~sync_q2[i];
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end
         end
      end
   end

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
   localparam int LW = (LONG_TICKS > 1) ? $clog2(LONG_TICKS + 1) : 1;
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TICKS);

   logic [LW-1:0] lcnt [CHANNELS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_long <= '0;
         for (int i = 0; i < CHANNELS; i++) lcnt[i] <= '0;
      end else begin
         btn_long <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            // Saturation at LONG_MAX guarantees a single pulse per hold.
            if (!btn_state[i]) begin
               lcnt[i] <= '0;
            end else if (rtg_btn && (lcnt[i] != LONG_MAX)) begin
               lcnt[i] <= lcnt[i] + 1'b1;
               if (lcnt[i] == LONG_MAX - 1'b1) btn_long[i] <= 1'b1;
            end
         end
      end
   end
`else
   assign btn_long = '0;
`endif

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: CHANNELS=2, STABLE_TICKS=3, LONG_TICKS=5, tick every 4th clk.
// Every press/release pulse is matched against an expected-event queue by a monitor.
module tb_btn_debounce_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rtg_btn;
   logic [1:0] btn;
   logic [1:0] btn_state;
   logic [1:0] btn_press;
   logic [1:0] btn_release;
   logic [1:0] btn_long;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int long_seen = 0;
   logic [3:0] exp_q[$];

   btn_debounce_multi #(
      .CHANNELS    (2),
      .STABLE_TICKS(3),
      .LONG_TICKS  (5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rtg_btn    (rtg_btn),
      .btn        (btn),
      .btn_state  (btn_state),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .btn_long   (btn_long)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      chk_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // One clk; inputs change at negedge, outputs are read 1 time unit after posedge.
   task automatic step(input logic t);
      @(negedge clk);
      rtg_btn = t;
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      step(1'b0);
      step(1'b0);
      step(1'b0);
      step(1'b1);
   endtask

   // Event monitor: each nonzero {press,release} must match the next expected event.
   always @(posedge clk) begin
      #1;
      if (btn_long[1] === 1'b1) long_seen++;
      if ((btn_press | btn_release) !== 2'b00) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {4'h0, btn_press, btn_release}, 8'h00);
         end else begin
            check("event", {4'h0, btn_press, btn_release}, {4'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      rtg_btn = 1'b0;
      btn     = 2'b11;
      repeat (5) step(1'b1);
      check("rst_state",   {6'h0, btn_state},   8'h00);
      check("rst_press",   {6'h0, btn_press},   8'h00);
      check("rst_release", {6'h0, btn_release}, 8'h00);
      check("rst_long",    {6'h0, btn_long},    8'h00);

      // Held buttons qualify after reset release
      rst_n = 1'b1;
      exp_q.push_back(4'b11_00);
      tick();
      check("post_rst_t1", {6'h0, btn_state}, 8'h00);
      tick();
      check("post_rst_t2", {6'h0, btn_state}, 8'h00);
      tick();
      check("post_rst_state", {6'h0, btn_state}, 8'h03);
      check("post_rst_press", {6'h0, btn_press}, 8'h03);
      step(1'b0);
      check("press_one_clk", {6'h0, btn_press}, 8'h00);

      // Release of channel 0
      btn = 2'b10;
      exp_q.push_back(4'b00_01);
      tick();
      tick();
      check("rel_t2_state", {6'h0, btn_state}, 8'h03);
      tick();
      check("rel_state",   {6'h0, btn_state},   8'h02);
      check("rel_release", {6'h0, btn_release}, 8'h01);
      step(1'b0);
      check("rel_one_clk", {6'h0, btn_release}, 8'h00);

      // Bounce 1,0,1,0 then stable 1 on channel 0
      btn = 2'b11; tick();
      btn = 2'b10; tick();
      btn = 2'b11; tick();
      btn = 2'b10; tick();
      check("bounce_state", {6'h0, btn_state}, 8'h02);
      btn = 2'b11;
      tick();
      tick();
      check("bounce_t2_state", {6'h0, btn_state}, 8'h02);
      exp_q.push_back(4'b01_00);
      tick();
      check("bounce_state_acc", {6'h0, btn_state}, 8'h03);
      check("bounce_press",     {6'h0, btn_press}, 8'h01);

      // Two-tick dip produces nothing
      btn = 2'b10;
      tick();
      tick();
      btn = 2'b11;
      tick();
      tick();
      tick();
      check("dip_state", {6'h0, btn_state}, 8'h03);

      // Release channel 0, then simultaneous press 0 / release 1
      btn = 2'b10;
      exp_q.push_back(4'b00_01);
      repeat (3) tick();
      check("rel2_state", {6'h0, btn_state}, 8'h02);
      btn = 2'b01;
      exp_q.push_back(4'b01_10);
      repeat (3) tick();
      check("sim_state",   {6'h0, btn_state},   8'h01);
      check("sim_press",   {6'h0, btn_press},   8'h01);
      check("sim_release", {6'h0, btn_release}, 8'h02);

      // Reset after 2 qualifying ticks discards the count
      btn = 2'b11;
      tick();
      tick();
      check("mid_pre_rst_state", {6'h0, btn_state}, 8'h01);
      rst_n = 1'b0;
      step(1'b0);
      rst_n = 1'b1;
      check("mid_rst_state", {6'h0, btn_state}, 8'h00);
      tick();
      tick();
      check("mid_requal_t2", {6'h0, btn_state}, 8'h00);
      exp_q.push_back(4'b11_00);
      tick();
      check("mid_requal_state", {6'h0, btn_state}, 8'h03);
      check("mid_requal_press", {6'h0, btn_press}, 8'h03);

      // Tick gating: 50 clk without rtg_btn
      btn = 2'b01;
      repeat (50) step(1'b0);
      check("gate_state", {6'h0, btn_state}, 8'h03);
      tick();
      tick();
      check("gate_t2_state", {6'h0, btn_state}, 8'h03);
      exp_q.push_back(4'b00_10);
      tick();
      check("gate_state_acc", {6'h0, btn_state},   8'h01);
      check("gate_release",   {6'h0, btn_release}, 8'h02);

      // Long press on channel 1
      btn = 2'b11;
      exp_q.push_back(4'b10_00);
      repeat (3) tick();
      check("long_press", {6'h0, btn_press}, 8'h02);
      long_seen = 0;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
      repeat (4) tick();
      check("long_early", long_seen[7:0], 8'd0);
      tick();
      check("long_pulse", {6'h0, btn_long}, 8'h02);
      repeat (10) tick();
      check("long_once", long_seen[7:0], 8'd1);
`else
      repeat (15) tick();
      check("long_off_seen", long_seen[7:0], 8'd0);
      check("long_off_out",  {6'h0, btn_long}, 8'h00);
`endif
      check("long_state", {6'h0, btn_state}, 8'h03);

      step(1'b0);
      check("exp_q_empty", exp_q.size(), 8'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
